// File: rtl/pcie_phy_pkg.sv
// Shared definitions for the PCIe PHY transmit path: byte width, PAD K-code
// and the striper state encoding.
package pcie_phy_pkg;

   localparam int BYTE_W = 8;
   localparam logic [BYTE_W-1:0] PAD_K = 8'hF7;

   typedef enum logic {
      EMPTY = 1'b0,
      HALF  = 1'b1
   } stripe_state_t;

endpackage

// File: rtl/byte_stripe_1to2.sv
// Two-lane byte striper: pairs consecutive valid bytes onto out0/out1.
// Define STRIPE_PAD_EN to flush a lone lane 0 byte with PAD_BYTE on an idle cycle.
module byte_stripe_1to2
   import pcie_phy_pkg::*;
#(
   parameter int                CNT_W    = 16,
   parameter logic [BYTE_W-1:0] PAD_BYTE = PAD_K
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [BYTE_W-1:0] data_in,
   input  logic              valid_in,
   output logic [BYTE_W-1:0] out0,
   output logic [BYTE_W-1:0] out1,
   output logic              valid_out,
   output logic              pad_out,
   output logic [CNT_W-1:0]  pair_cnt
);

   stripe_state_t     state, state_next;
   logic [BYTE_W-1:0] hold, hold_next;
   logic [BYTE_W-1:0] out0_next, out1_next;
   logic              valid_next, pad_next;
   logic [CNT_W-1:0]  cnt_next;

   // Outputs are registered so a pair appears the cycle after its lane 1 byte.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= EMPTY;
         hold      <= '0;
         out0      <= '0;
         out1      <= '0;
         valid_out <= 1'b0;
         pair_cnt  <= '0;
      end else begin
         state     <= state_next;
         hold      <= hold_next;
         out0      <= out0_next;
         out1      <= out1_next;
         valid_out <= valid_next;
         pair_cnt  <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      hold_next  = hold;
      out0_next  = out0;
      out1_next  = out1;
      valid_next = 1'b0;
      pad_next   = 1'b0;
      cnt_next   = pair_cnt;
      case (state)
         EMPTY: begin
            if (valid_in) begin
               hold_next  = data_in;
               state_next = HALF;
            end
         end
         HALF: begin
            if (valid_in) begin
               out0_next  = hold;
               out1_next  = data_in;
               valid_next = 1'b1;
               cnt_next   = pair_cnt + CNT_W'(1);
               state_next = EMPTY;
            end else begin
`ifdef STRIPE_PAD_EN
               out0_next  = hold;
               out1_next  = PAD_BYTE;
               valid_next = 1'b1;
               pad_next   = 1'b1;
               cnt_next   = pair_cnt + CNT_W'(1);
               state_next = EMPTY;
`endif
            end
         end
         default: state_next = EMPTY;
      endcase
   end

`ifdef STRIPE_PAD_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pad_out <= 1'b0;
      else        pad_out <= pad_next;
   end
`else
   // Without flushing the lane 1 byte is never PAD, so the flag is constant.
   logic unused_pad;
   assign unused_pad = pad_next ^ (^PAD_BYTE);
   assign pad_out    = 1'b0;
`endif

endmodule

// File: tb/tb_byte_stripe_1to2.sv
// Directed self-checking bench for byte_stripe_1to2; expectations follow
// STRIPE_PAD_EN when the bench is built with it defined.
module tb_byte_stripe_1to2;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  data_in;
   logic        valid_in;
   logic [7:0]  out0, out1, w_out0, w_out1;
   logic        valid_out, pad_out, w_valid, w_pad;
   logic [15:0] pair_cnt;
   logic [3:0]  w_cnt;
   int          total = 0;
   int          bad   = 0;
   logic [15:0] exp_cnt;

   byte_stripe_1to2 dut (
      .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .out0(out0), .out1(out1), .valid_out(valid_out), .pad_out(pad_out),
      .pair_cnt(pair_cnt)
   );

   // Narrow-counter instance shares the stimulus and exercises wrap-around.
   byte_stripe_1to2 #(.CNT_W(4)) dut_w (
      .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .out0(w_out0), .out1(w_out1), .valid_out(w_valid), .pad_out(w_pad),
      .pair_cnt(w_cnt)
   );

   always #5 clk = ~clk;

   // Drive one cycle of input, then sample 1 time unit after the edge.
   task automatic cycle(input logic v, input logic [7:0] d);
      valid_in = v;
      data_in  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0; valid_in = 1'b0; data_in = 8'h00;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      total++;
      if ({out0, out1, valid_out, pad_out, pair_cnt} !== 34'd0) begin
         bad++; $display("FAIL reset_init got=%h want=0", {out0, out1, valid_out, pad_out, pair_cnt});
      end
      cycle(1'b1, 8'hC1);
      cycle(1'b1, 8'hC2);
      total++;
      if ({valid_out, out0, out1, pair_cnt} !== {1'b1, 8'hC1, 8'hC2, 16'd1}) begin
         bad++; $display("FAIL reset_prepair got=%h want=%h", {valid_out, out0, out1, pair_cnt}, {1'b1, 8'hC1, 8'hC2, 16'd1});
      end
      #2 reset = 1'b0;
      #1;
      total++;
      if ({out0, out1, valid_out, pad_out, pair_cnt} !== 34'd0) begin
         bad++; $display("FAIL reset_async got=%h want=0", {out0, out1, valid_out, pad_out, pair_cnt});
      end
      @(posedge clk);
      #1 reset = 1'b1;
      exp_cnt = 16'd0;
   endtask

   task automatic test_stream;
      logic [7:0] e0, e1;
      e0 = 8'h00; e1 = 8'h00;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 8'(i + 1));
         if (i % 2 == 1) begin
            e0 = 8'(i); e1 = 8'(i + 1); exp_cnt = exp_cnt + 16'd1;
         end
         total++;
         if ({valid_out, pad_out, out0, out1, pair_cnt} !== {(i % 2 == 1), 1'b0, e0, e1, exp_cnt}) begin
            bad++; $display("FAIL stream_%0d got=%h want=%h", i,
               {valid_out, pad_out, out0, out1, pair_cnt}, {(i % 2 == 1), 1'b0, e0, e1, exp_cnt});
         end
      end
      cycle(1'b0, 8'hEE);
      total++;
      if ({valid_out, out0, out1, pair_cnt} !== {1'b0, 8'h05, 8'h06, 16'd3}) begin
         bad++; $display("FAIL stream_hold got=%h want=%h", {valid_out, out0, out1, pair_cnt}, {1'b0, 8'h05, 8'h06, 16'd3});
      end
   endtask

   task automatic test_gap;
      cycle(1'b1, 8'hAA);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 8'h5A);
`ifdef STRIPE_PAD_EN
         if (i == 0) exp_cnt = exp_cnt + 16'd1;
         total++;
         if ({valid_out, pad_out, out0, out1, pair_cnt} !== {(i == 0), (i == 0), 8'hAA, 8'hF7, exp_cnt}) begin
            bad++; $display("FAIL gap_idle_%0d got=%h want=%h", i,
               {valid_out, pad_out, out0, out1, pair_cnt}, {(i == 0), (i == 0), 8'hAA, 8'hF7, exp_cnt});
         end
`else
         total++;
         if ({valid_out, pad_out, out0, out1, pair_cnt} !== {2'b00, 8'h05, 8'h06, exp_cnt}) begin
            bad++; $display("FAIL gap_idle_%0d got=%h want=%h", i,
               {valid_out, pad_out, out0, out1, pair_cnt}, {2'b00, 8'h05, 8'h06, exp_cnt});
         end
`endif
      end
      cycle(1'b1, 8'hBB);
`ifdef STRIPE_PAD_EN
      total++;
      if ({valid_out, pair_cnt} !== {1'b0, exp_cnt}) begin
         bad++; $display("FAIL gap_bb_held got=%h want=%h", {valid_out, pair_cnt}, {1'b0, exp_cnt});
      end
      cycle(1'b0, 8'h00);
      exp_cnt = exp_cnt + 16'd1;
      total++;
      if ({valid_out, pad_out, out0, out1, pair_cnt} !== {2'b11, 8'hBB, 8'hF7, exp_cnt}) begin
         bad++; $display("FAIL gap_bb_flush got=%h want=%h", {valid_out, pad_out, out0, out1, pair_cnt}, {2'b11, 8'hBB, 8'hF7, exp_cnt});
      end
`else
      exp_cnt = exp_cnt + 16'd1;
      total++;
      if ({valid_out, pad_out, out0, out1, pair_cnt} !== {2'b10, 8'hAA, 8'hBB, exp_cnt}) begin
         bad++; $display("FAIL gap_pair got=%h want=%h", {valid_out, pad_out, out0, out1, pair_cnt}, {2'b10, 8'hAA, 8'hBB, exp_cnt});
      end
      cycle(1'b0, 8'h00);
      total++;
      if (valid_out !== 1'b0) begin
         bad++; $display("FAIL gap_after got=%b want=0", valid_out);
      end
`endif
   endtask

   task automatic test_odd_burst;
      cycle(1'b1, 8'h10);
      cycle(1'b1, 8'h11);
      exp_cnt = exp_cnt + 16'd1;
      total++;
      if ({valid_out, pad_out, out0, out1, pair_cnt} !== {2'b10, 8'h10, 8'h11, exp_cnt}) begin
         bad++; $display("FAIL odd_pair got=%h want=%h", {valid_out, pad_out, out0, out1, pair_cnt}, {2'b10, 8'h10, 8'h11, exp_cnt});
      end
      cycle(1'b1, 8'h12);
      cycle(1'b0, 8'h00);
`ifdef STRIPE_PAD_EN
      exp_cnt = exp_cnt + 16'd1;
      total++;
      if ({valid_out, pad_out, out0, out1, pair_cnt} !== {2'b11, 8'h12, 8'hF7, exp_cnt}) begin
         bad++; $display("FAIL odd_flush got=%h want=%h", {valid_out, pad_out, out0, out1, pair_cnt}, {2'b11, 8'h12, 8'hF7, exp_cnt});
      end
`else
      total++;
      if ({valid_out, out0, out1, pair_cnt} !== {1'b0, 8'h10, 8'h11, exp_cnt}) begin
         bad++; $display("FAIL odd_hold got=%h want=%h", {valid_out, out0, out1, pair_cnt}, {1'b0, 8'h10, 8'h11, exp_cnt});
      end
      cycle(1'b1, 8'h13);
      exp_cnt = exp_cnt + 16'd1;
      total++;
      if ({valid_out, out0, out1, pair_cnt} !== {1'b1, 8'h12, 8'h13, exp_cnt}) begin
         bad++; $display("FAIL odd_late got=%h want=%h", {valid_out, out0, out1, pair_cnt}, {1'b1, 8'h12, 8'h13, exp_cnt});
      end
`endif
   endtask

   task automatic test_reset_mid_pair;
      cycle(1'b1, 8'h55);
      valid_in = 1'b0;
      #2 reset = 1'b0;
      #1;
      total++;
      if ({out0, out1, valid_out, pad_out, pair_cnt} !== 34'd0) begin
         bad++; $display("FAIL midreset_clear got=%h want=0", {out0, out1, valid_out, pad_out, pair_cnt});
      end
      @(posedge clk);
      #1 reset = 1'b1;
      cycle(1'b1, 8'h66);
      total++;
      if ({valid_out, out0, out1} !== 17'd0) begin
         bad++; $display("FAIL midreset_first got=%h want=0", {valid_out, out0, out1});
      end
      cycle(1'b1, 8'h77);
      total++;
      if ({valid_out, pad_out, out0, out1, pair_cnt} !== {2'b10, 8'h66, 8'h77, 16'd1}) begin
         bad++; $display("FAIL midreset_pair got=%h want=%h", {valid_out, pad_out, out0, out1, pair_cnt}, {2'b10, 8'h66, 8'h77, 16'd1});
      end
   endtask

   task automatic test_wrap;
      valid_in = 1'b0;
      #2 reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      for (int p = 1; p <= 17; p++) begin
         cycle(1'b1, 8'(2 * p));
         cycle(1'b1, 8'(2 * p + 1));
         if (p >= 15) begin
            total++;
            if ({w_valid, w_out0, w_out1, w_cnt} !== {1'b1, 8'(2 * p), 8'(2 * p + 1), 4'(p)}) begin
               bad++; $display("FAIL wrap_%0d got=%h want=%h", p,
                  {w_valid, w_out0, w_out1, w_cnt}, {1'b1, 8'(2 * p), 8'(2 * p + 1), 4'(p)});
            end
         end
      end
      total++;
      if (pair_cnt !== 16'd17) begin
         bad++; $display("FAIL wrap_wide got=%0d want=17", pair_cnt);
      end
   endtask

   initial begin
      test_reset;
      test_stream;
      test_gap;
      test_odd_burst;
      test_reset_mid_pair;
      test_wrap;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/byte_stripe_1to2.md
# byte_stripe_1to2

Two-lane byte striper for the PCIe physical-layer transmit path. Takes a single 8-bit byte stream with a valid qualifier and distributes consecutive bytes alternately onto lane 0 and lane 1, presenting each completed pair at once. Sits directly upstream of the two-lane 8-bit pipeline register stage, whose in0/in1 inputs it drives. Also tracks a wrapping count of emitted pairs for debug and verification.

## Interface
- CNT_W, 16: width of the emitted-pair counter.
- PAD_BYTE, 8'hF7: byte placed on lane 1 when a partial pair is flushed (K23.7 PAD); used only with STRIPE_PAD_EN.
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low; reset==0 clears all state immediately, independent of clk.
- data_in  in  8  incoming byte.
- valid_in  in  1  data_in is valid this cycle.
- out0  out  8  lane 0 byte (earlier byte of pair).
- out1  out  8  lane 1 byte (later byte of pair).
- valid_out  out  1  out0/out1 hold a new pair this cycle; single-cycle pulse per pair.
- pad_out  out  1  current pair's lane 1 is PAD_BYTE (flush); always 0 without STRIPE_PAD_EN.
- pair_cnt  out  CNT_W  number of pairs emitted, modulo 2^CNT_W.

## Operation
- Reset values: out0=0, out1=0, valid_out=0, pad_out=0, pair_cnt=0, hold register=0, state=EMPTY.
- FSM, two states:
  - EMPTY (no byte held): valid_in=1 -> capture data_in into hold, go HALF. valid_in=0 -> stay.
  - HALF (lane 0 byte held): valid_in=1 -> out0<=hold, out1<=data_in, valid_out<=1, pad_out<=0, pair_cnt++, go EMPTY.
  - HALF, valid_in=0: see Configuration.
- Strict alternation: first valid byte after reset always goes to lane 0; ordering never swaps.
- out0/out1 hold their last value when valid_out=0; they change only on emission.
- pair_cnt increments by 1 on every emission (data or flush), wraps from 2^CNT_W-1 to 0 with no flag.
- data_in ignored when valid_in=0.

## Timing
- Byte A valid at cycle n, byte B valid at cycle n+1 -> out0=A, out1=B, valid_out=1 during cycle n+2.
- Latency: 1 cycle from the cycle carrying the lane 1 byte to valid_out.
- Back-to-back valid input -> valid_out asserted every other cycle, never two consecutive cycles.
- Gaps in valid_in between lane 0 and lane 1 bytes are allowed; the pair is emitted the cycle after the lane 1 byte arrives (without STRIPE_PAD_EN).
- Reset asserted mid-pair: held byte discarded, all outputs to reset values asynchronously; after deassertion the next valid byte is lane 0.
- Reset deasserted: first capture at the first posedge with reset=1 and valid_in=1.

## Configuration
- STRIPE_PAD_EN defined: in HALF with valid_in=0, flush: out0<=hold, out1<=PAD_BYTE, valid_out<=1, pad_out<=1, pair_cnt++, go EMPTY. A one-cycle input gap after an odd byte therefore emits a padded pair 1 cycle later.
- STRIPE_PAD_EN undefined: HALF with valid_in=0 stays in HALF, holding the byte indefinitely; pad_out tied 0; PAD_BYTE unused.

## Structure
- Shared package pcie_phy_pkg: BYTE_W=8, PAD K-code constant (8'hF7), FSM state enum {EMPTY, HALF}.
- Single flat module; no sub-module is warranted (one hold register, two-state FSM, counter).

## Test plan
- Reset: drive reset=0 mid-cycle without a clock edge -> all outputs 0 immediately; pair_cnt=0.
- Continuous stream 8'h01..8'h06 on consecutive cycles -> pairs (01,02),(03,04),(05,06), each valid_out pulse 2 cycles apart; pair_cnt=3.
- Gapped pair: 8'hAA, 3 idle cycles, 8'hBB. Without STRIPE_PAD_EN -> single pair (AA,BB) one cycle after BB. With STRIPE_PAD_EN -> (AA,F7) with pad_out=1, then BB held as lane 0.
- Odd-length burst 8'h10,8'h11,8'h12 then idle, STRIPE_PAD_EN -> (10,11) pad_out=0, then (12,F7) pad_out=1; pair_cnt=2.
- Reset mid-pair: send 8'h55, assert reset, release, send 8'h66,8'h77 -> only pair (66,77); 55 never appears.
- Counter wrap with CNT_W=4: emit 17 pairs -> pair_cnt reads 15 after 15 pairs, 0 after 16, 1 after 17.
